rst_seq_ctrl: RTL and testbench



---
 rtl/rst_pkg.sv | 14 +
 rtl/rst_sync_chain.sv | 19 +
 rtl/rst_seq_ctrl.sv | 118 +++++++++++
 tb/tb_rst_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencing controller: FSM encoding and reset cause codes.
package rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic CAUSE_POR = 1'b0;
  localparam logic CAUSE_SW  = 1'b1;

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchroniser: asynchronous assert, release after NUM_STAGES edges with RST_n high.
module rst_sync_chain #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_n,
  output logic sync_q
);

  logic [NUM_STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) chain <= '0;
    else        chain <= {chain[NUM_STAGES-2:0], 1'b1};
  end

  assign sync_q = chain[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer: synchronised release, hold stretch, staggered
// per-channel release with enable masking, and software reset from RUN.
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned MIN_HOLD   = 4,
  parameter int unsigned REL_GAP    = 2
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              SW_RST_REQ,
  input  logic [NUM_CH-1:0] EN_MASK,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic              RST_CAUSE
);

  localparam int unsigned CNT_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned GAP_W = $clog2(REL_GAP + 1);
  localparam int unsigned IDX_W = $clog2(NUM_CH + 1);

  logic              sync_q;
  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [GAP_W-1:0]  gap, gap_d;
  logic [IDX_W-1:0]  idx, idx_d, idx_inc;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              cause_q, cause_d;

  rst_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_sync (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .sync_q (sync_q)
  );

  assign idx_inc = idx + IDX_W'(1);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= HOLD;
      cnt     <= '0;
      gap     <= '0;
      idx     <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      gap     <= gap_d;
      idx     <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // Disabling a channel pulls its reset low on the next edge; enabling only takes effect at its release slot.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gap_d   = gap;
    idx_d   = idx;
    rst_d   = rst_q & EN_MASK;
    done_d  = done_q;
    cause_d = cause_q;
    case (state)
      HOLD: begin
        if (sync_q) begin
          state_d = STRETCH;
          cnt_d   = '0;
        end
      end
      STRETCH: begin
        if (cnt == CNT_W'(MIN_HOLD - 1)) begin
          state_d  = RELEASE;
          gap_d    = '0;
          idx_d    = '0;
          rst_d[0] = EN_MASK[0];
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (idx == IDX_W'(NUM_CH - 1)) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else if (gap == GAP_W'(REL_GAP - 1)) begin
          gap_d = '0;
          idx_d = idx_inc;
          for (int k = 1; k < NUM_CH; k++) begin
            if (idx_inc == IDX_W'(k)) rst_d[k] = EN_MASK[k];
          end
        end else begin
          gap_d = gap + GAP_W'(1);
        end
      end
      RUN: begin
        if (SW_RST_REQ) begin
          state_d = STRETCH;
          cnt_d   = '0;
          rst_d   = '0;
          done_d  = 1'b0;
          cause_d = CAUSE_SW;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign SYNC_RST  = rst_q;
  assign RST_DONE  = done_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: vector table, directed corner sequences and
// randomized traffic against an edge-count based reference model.
module tb_rst_seq_ctrl;

  localparam int NS = 2, NC = 3, MH = 4, RG = 2;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          SW_RST_REQ = 1'b0;
  logic [NC-1:0] EN_MASK = '1;
  logic [NC-1:0] SYNC_RST;
  logic          RST_DONE, RST_CAUSE;

  logic          sw2 = 1'b0;
  logic [0:0]    en2 = 1'b1;
  logic [0:0]    sync2;
  logic          done2, cause2;

  int tests = 0;
  int fails = 0;

  // reference model state
  int            n;
  int            base;
  bit            active, in_run;
  logic [NC-1:0] exp_sync;
  logic          exp_done, exp_cause;

  typedef struct {
    logic          sw;
    logic [NC-1:0] mask;
    logic [NC-1:0] sync;
    logic          done;
    logic          cause;
    logic          sync2;
    logic          done2;
  } vec_t;
  vec_t tbl[13];

  always #5 CLK = ~CLK;

  rst_seq_ctrl #(.NUM_STAGES(NS), .NUM_CH(NC), .MIN_HOLD(MH), .REL_GAP(RG)) dut (
    .CLK(CLK), .RST_n(RST_n), .SW_RST_REQ(SW_RST_REQ), .EN_MASK(EN_MASK),
    .SYNC_RST(SYNC_RST), .RST_DONE(RST_DONE), .RST_CAUSE(RST_CAUSE)
  );

  rst_seq_ctrl #(.NUM_STAGES(4), .NUM_CH(1), .MIN_HOLD(1), .REL_GAP(1)) dut2 (
    .CLK(CLK), .RST_n(RST_n), .SW_RST_REQ(sw2), .EN_MASK(en2),
    .SYNC_RST(sync2), .RST_DONE(done2), .RST_CAUSE(cause2)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, n, act, req);
    end
  endtask

  task automatic model_reset();
    n = 0; base = 0; active = 0; in_run = 0;
    exp_sync = '0; exp_done = 1'b0; exp_cause = 1'b0;
  endtask

  // Release times follow from the sequence start edge by plain arithmetic.
  task automatic model_step(input logic sw, input logic [NC-1:0] m);
    logic [NC-1:0] ns;
    n++;
    ns = exp_sync & m;
    if (in_run) begin
      if (sw) begin
        ns = '0; exp_done = 1'b0; exp_cause = 1'b1;
        base = n; active = 1; in_run = 0;
      end
    end else if (active) begin
      for (int k = 0; k < NC; k++)
        if (n == base + MH + k * RG) ns[k] = m[k];
      if (n == base + MH + (NC - 1) * RG + 1) begin
        exp_done = 1'b1; in_run = 1; active = 0;
      end
    end else if (n == NS + 1) begin
      base = n; active = 1;
    end
    exp_sync = ns;
  endtask

  // One clock: drive at negedge, model on the edge, compare #1 later, return at negedge.
  task automatic cycle(input logic sw, input logic [NC-1:0] m);
    SW_RST_REQ = sw;
    EN_MASK    = m;
    @(posedge CLK);
    model_step(sw, m);
    #1;
    check("model", 8'({SYNC_RST, RST_DONE, RST_CAUSE}), 8'({exp_sync, exp_done, exp_cause}));
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    #1;
    check("async_clear", 8'({SYNC_RST, RST_DONE, RST_CAUSE}), 8'd0);
    check("async_clear2", 8'({sync2, done2, cause2}), 8'd0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    SW_RST_REQ = 1'b0;
    RST_n = 1'b1;
  endtask

  task automatic run_table();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].sw, tbl[i].mask);
      check("tbl_sync", 8'(SYNC_RST), 8'(tbl[i].sync));
      check("tbl_done", 8'(RST_DONE), 8'(tbl[i].done));
      check("tbl_cause", 8'(RST_CAUSE), 8'(tbl[i].cause));
      check("tbl_small", 8'({sync2, done2}), 8'({tbl[i].sync2, tbl[i].done2}));
    end
  endtask

  initial begin
    // default sequence, edges 1..13
    for (int i = 0; i < 13; i++) begin
      automatic int e = i + 1;
      tbl[i].sw    = 1'b0;
      tbl[i].mask  = 3'b111;
      tbl[i].sync  = (e >= 11) ? 3'b111 : (e >= 9) ? 3'b011 : (e >= 7) ? 3'b001 : 3'b000;
      tbl[i].done  = (e >= 12);
      tbl[i].cause = 1'b0;
      tbl[i].sync2 = (e >= 6);
      tbl[i].done2 = (e >= 7);
    end

    model_reset();
    @(negedge CLK);
    do_reset();
    run_table();

    // software reset pulse at edge 20
    while (n < 19) cycle(1'b0, 3'b111);
    cycle(1'b1, 3'b111);
    check("sw_clear", 8'({SYNC_RST, RST_DONE, RST_CAUSE}), 8'b0000_0001);
    while (n < 30) begin
      cycle(1'b0, 3'b111);
      case (n)
        23: check("sw_e23", 8'(SYNC_RST), 8'b000);
        24: check("sw_e24", 8'(SYNC_RST), 8'b001);
        26: check("sw_e26", 8'(SYNC_RST), 8'b011);
        28: check("sw_e28", 8'({SYNC_RST, RST_DONE}), 8'b1110);
        29: check("sw_e29", 8'({SYNC_RST, RST_DONE, RST_CAUSE}), 8'b11111);
        default: ;
      endcase
    end

    // mask clear and re-enable in RUN, then SW reset
    cycle(1'b0, 3'b110);
    check("mask_clr", 8'(SYNC_RST), 8'b110);
    cycle(1'b0, 3'b111);
    check("mask_reen", 8'(SYNC_RST), 8'b110);
    cycle(1'b0, 3'b111);
    check("mask_reen2", 8'(SYNC_RST), 8'b110);
    cycle(1'b1, 3'b111);
    begin
      automatic int s = n;
      while (n < s + 4) cycle(1'b0, 3'b111);
      check("mask_sw_rel", 8'({SYNC_RST, RST_CAUSE}), 8'b0011);
    end

    // RST_n during a software sequence: cause returns to POR
    cycle(1'b0, 3'b111);
    do_reset();

    // RST_n mid-RELEASE, between edges 9 and 10
    while (n < 9) cycle(1'b0, 3'b111);
    check("pre_abort", 8'(SYNC_RST), 8'b011);
    do_reset();
    run_table();

    // SW request during STRETCH is ignored
    do_reset();
    while (n < 3) cycle(1'b0, 3'b111);
    while (n < 6) cycle(1'b1, 3'b111);
    while (n < 12) begin
      cycle(1'b0, 3'b111);
      if (n == 7)  check("stretch_sw_e7", 8'(SYNC_RST), 8'b001);
      if (n == 11) check("stretch_sw_e11", 8'(SYNC_RST), 8'b111);
    end
    check("stretch_sw_done", 8'({RST_DONE, RST_CAUSE}), 8'b10);

    // masked middle channel keeps its slot
    do_reset();
    while (n < 12) begin
      cycle(1'b0, 3'b101);
      if (n == 10) check("m101_e10", 8'(SYNC_RST), 8'b001);
      if (n == 11) check("m101_e11", 8'({SYNC_RST, RST_DONE}), 8'b1010);
    end
    check("m101_done", 8'({SYNC_RST, RST_DONE}), 8'b1011);

    // randomized traffic
    for (int seg = 0; seg < 4; seg++) begin
      automatic logic [NC-1:0] m = 3'b111;
      do_reset();
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 9) == 0) m = NC'($urandom);
        cycle($urandom_range(0, 7) == 0, m);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
